// File: rtl/traffic_pkg.sv
// Shared light encodings, phase codes and head decode
// for the two-road intersection scheduler.
package traffic_pkg;

   localparam logic [1:0] RED    = 2'b00;
   localparam logic [1:0] YELLOW = 2'b01;
   localparam logic [1:0] GREEN  = 2'b10;

   typedef enum logic [2:0] {
      HG  = 3'd0,
      HY  = 3'd1,
      AR1 = 3'd2,
      CG  = 3'd3,
      CY  = 3'd4,
      AR2 = 3'd5
   } phase_e;

   function automatic logic [1:0] hw_head(phase_e p);
      case (p)
         HG:      return GREEN;
         HY:      return YELLOW;
         default: return RED;
      endcase
   endfunction

   function automatic logic [1:0] cr_head(phase_e p);
      case (p)
         CG:      return GREEN;
         CY:      return YELLOW;
         default: return RED;
      endcase
   endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Demand inputs and signal-head outputs of the
// phase scheduler.
interface traffic_phase_scheduler_if;

   logic       tick;
   logic       car_req;
   logic       ped_req;
   logic       emg_req;
   logic [1:0] highway;
   logic [1:0] cross_road;
   logic       walk;
   logic       ped_pending;
   logic       ped_ack;
   logic [2:0] phase;

   modport master (
      output tick, car_req, ped_req, emg_req,
      input  highway, cross_road, walk,
      input  ped_pending, ped_ack, phase
   );

   modport slave (
      input  tick, car_req, ped_req, emg_req,
      output highway, cross_road, walk,
      output ped_pending, ped_ack, phase
   );

endinterface

// File: rtl/phase_timer.sv
// Saturating tick counter with synchronous clear and
// an elapsed flag against a caller-supplied threshold.
module phase_timer #(
   parameter int CW = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          tick_i,
   input  logic [CW-1:0] thr_i,
   output logic          elapsed_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (tick_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // thr_i is T-1, so this reads "T ticks seen"
   assign elapsed_o = tick_i && (cnt_q >= thr_i);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Tick-timed phase FSM, pedestrian latch and registered
// head decode for a highway / cross-road intersection.
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int CW       = 8,
   parameter int T_HW_MIN = 8,
   parameter int T_YEL    = 3,
   parameter int T_ALLRED = 2,
   parameter int T_CR_MIN = 4,
   parameter int T_CR_MAX = 10
) (
   input logic clk,
   input logic clear_n,
   traffic_phase_scheduler_if.slave bus
);

   localparam int TMAX = 2 ** CW;

   if (T_HW_MIN < 1 || T_YEL < 1 || T_ALLRED < 1 ||
       T_CR_MIN < 1 || T_CR_MAX < T_CR_MIN ||
       T_HW_MIN >= TMAX || T_YEL >= TMAX ||
       T_ALLRED >= TMAX || T_CR_MAX >= TMAX)
   begin : g_bad_params
      $error("traffic_phase_scheduler: illegal timing");
   end

   localparam logic [CW-1:0] TH_HW  = CW'(T_HW_MIN - 1);
   localparam logic [CW-1:0] TH_YEL = CW'(T_YEL - 1);
   localparam logic [CW-1:0] TH_AR  = CW'(T_ALLRED - 1);
   localparam logic [CW-1:0] TH_CRN = CW'(T_CR_MIN - 1);
   localparam logic [CW-1:0] TH_CRX = CW'(T_CR_MAX - 1);

   phase_e        state_q, state_d;
   logic [1:0]    hw_q, cr_q;
   logic          walk_q, pend_q, ack_q;
   logic [CW-1:0] thr;
   logic          elapsed;
   logic          clr;
   logic          enter_cg;
   logic          serve;

   // With car demand only the maximum ends CG; without it
   // the minimum does, and T_CR_MIN <= T_CR_MAX.
   always_comb begin
      thr = '0;
      case (state_q)
         HG:       thr = TH_HW;
         HY, CY:   thr = TH_YEL;
         AR1, AR2: thr = TH_AR;
         CG:       thr = bus.car_req ? TH_CRX : TH_CRN;
         default:  thr = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         HG:  if (elapsed && !bus.emg_req &&
                  (bus.car_req || pend_q))
                 state_d = HY;
         HY:  if (elapsed) state_d = AR1;
         AR1: if (elapsed) state_d = CG;
         CG:  if (elapsed || bus.emg_req) state_d = CY;
         CY:  if (elapsed) state_d = AR2;
         AR2: if (elapsed) state_d = HG;
         default: state_d = HG;
      endcase
   end

   assign clr      = (state_d != state_q);
   assign enter_cg = (state_d == CG) && (state_q != CG);
   assign serve    = enter_cg && pend_q;

   phase_timer #(
      .CW(CW)
   ) u_timer (
      .clk_i     (clk),
      .rst_ni    (clear_n),
      .clr_i     (clr),
      .tick_i    (bus.tick),
      .thr_i     (thr),
      .elapsed_o (elapsed)
   );

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= HG;
         hw_q    <= GREEN;
         cr_q    <= RED;
         walk_q  <= 1'b0;
         pend_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hw_q    <= hw_head(state_d);
         cr_q    <= cr_head(state_d);
         ack_q   <= serve;
         // clear beats a same-edge ped_req at CG entry
         pend_q  <= serve ? 1'b0 : (pend_q | bus.ped_req);
         walk_q  <= (state_d == CG) && (serve || walk_q);
      end
   end

   assign bus.highway     = hw_q;
   assign bus.cross_road  = cr_q;
   assign bus.walk        = walk_q;
   assign bus.ped_pending = pend_q;
   assign bus.ped_ack     = ack_q;
   assign bus.phase       = state_q;

endmodule
